gray2bin_arbiter: RTL and testbench
===================================

# gray2bin_arbiter

Shares a single Gray-to-binary conversion stage between N requesters. It round-robin arbitrates incoming Gray codes, converts the winner and holds the result in a one-entry output register. The result is drained through a valid/ready handshake. It sits between the Gray-coded sources (counters, encoders) and the binary consumers that previously each needed a private converter.

## Interface
- W, 4: Gray/binary code width, W ≥ 2.
- N, 2: number of requesters, N ≥ 2.
- IDW, max(1, $clog2(N)): requester-id width (derived, not overridden).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N  bit i: requester i presents a code.
- req_gray  in  N*W  requester i code on bits [i*W +: W].
- req_ready  out  N  one-hot or zero; bit i means requester i's code is taken this cycle.
- out_valid  out  1  output slot holds a result.
- out_gray  out  W  Gray code as accepted.
- out_bin  out  W  converted binary value.
- out_id  out  IDW  index of the requester that supplied the code.
- out_ready  in  1  consumer takes the result this cycle.

## Operation
- Conversion: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i] for i = W-2 down to 0. The result is computed at accept time and registered alongside out_gray.
- Slot states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- can_accept = EMPTY, or (FULL and out_ready).
- Arbitration: round-robin pointer ptr in [0, N-1].
  - The winner is the first i with req_valid[i], scanning ptr, ptr+1, … with wrap at N.
  - If can_accept and any req_valid, then req_ready[winner] = 1 and all other bits are 0. Otherwise req_ready = 0.
  - req_ready is combinational from req_valid, state and ptr. It never depends on req_gray.
- Accept: on the edge where req_ready[i] = 1:
  - load out_gray, out_bin and out_id = i;
  - ptr ← (i + 1) mod N;
  - state becomes FULL.
- Drain: FULL with out_ready and no accept leads to EMPTY. Data registers hold their last values; only out_valid drops.
- FULL with out_ready low: outputs stay stable, req_ready = 0 and ptr does not change.
- EMPTY with no req_valid: no change, ptr held.
- A requester must hold req_valid and req_gray stable until it sees req_ready. The block does not check this.
- Reset (asynchronous, any state, mid-transfer included):
  - state EMPTY, out_valid 0, out_gray 0, out_bin 0, out_id 0, ptr 0;
  - req_ready forced to 0 while rst is high;
  - an in-flight result is discarded.

## Timing
- Latency: a code accepted at edge k appears with out_valid = 1 right after edge k, i.e. 1 cycle.
- Throughput: 1 result per cycle while out_ready stays high and requests are present (drain and refill happen on the same edge).
- Fairness: with all N requesters continuously valid and out_ready high, grants cycle 0, 1, …, N-1, 0, … and each requester waits at most N-1 grants.
- No combinational path from out_ready to out_valid, out_gray, out_bin or out_id.
- Combinational paths out_ready → req_ready and req_valid → req_ready are allowed.
- Reset release: the first accept is possible on the first edge after rst falls.

## Structure
- Package g2b_pkg:
  - default W and N;
  - the state encoding (EMPTY = 1'b0, FULL = 1'b1);
  - a function computing IDW from N.
- Sub-module gray2bin_comb: purely combinational W-bit Gray-to-binary converter, instantiated once on the muxed winner code.
- The top level contains the round-robin arbiter, the accept mux, the slot state and the output registers.

## Test plan
All scenarios use W = 4, N = 2 unless stated.
- Reset values: assert rst mid-FULL (out_valid = 1, out_gray = 4'b1101).
  - Required: outputs go to 0 immediately, without waiting for an edge.
  - Required: req_ready = 0 while rst is high, and ptr = 0 afterwards (requester 0 wins the first tie).
- Full sweep: requester 0 alone, gray 0000 through 1000 in sequence, out_ready = 1.
  - Required: out_bin follows the standard table, e.g. 0110 → 0100, 1101 → 1001, 1000 → 1111.
  - Required: one result per cycle, out_id = 0.
- Round-robin: both requesters continuously valid (r0 = 0011, r1 = 1111), out_ready = 1.
  - Required: grants alternate 0, 1, 0, 1.
  - Required: out_bin alternates 0010 / 1010 and out_id alternates 0 / 1.
- Backpressure: out_ready = 0 for 3 cycles with both requesters valid.
  - Required: the slot holds its value and req_ready = 0 throughout.
  - Required: on out_ready = 1 the drain and the next accept happen on the same edge, and the grant goes to the requester after the last winner.
- Idle drain: single request with gray 0101, then out_ready pulsed once and no further requests.
  - Required: out_bin = 0110 held until the pulse; out_valid = 0 the cycle after; ptr unchanged with no requests.
- N = 3 wrap: only requesters 2 and 0 valid, starting from ptr = 2.
  - Required: grant order 2, 0, 2; requester 1 (idle) is skipped with no bubble cycles.

Source files
------------

// File: rtl/gray2bin_arbiter_pkg.sv
// Shared definitions for the Gray-to-binary arbiter slice.
// Contents: default code width and requester count, the output slot state
// encoding, and the requester-id width helper used by the interface and top.
package g2b_pkg;

   localparam int G2B_W = 4;
   localparam int G2B_N = 2;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Requester-id width: max(1, clog2(n)) so that N = 2 still gets one bit.
   function automatic int calc_idw(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gray2bin_arbiter_if.sv
// Request/result bundle between Gray-coded sources, the shared converter and
// the binary consumer.
//   req_valid[N]   requester i presents a code
//   req_gray[N*W]  requester i code on bits [i*W +: W]
//   req_ready[N]   one-hot grant: requester i's code is taken this cycle
//   out_valid      result slot is full
//   out_gray[W]    accepted Gray code
//   out_bin[W]     converted binary value
//   out_id[IDW]    index of the requester that supplied the code
//   out_ready      consumer takes the result this cycle
// slave: the arbiter side; master: the sources/consumer side.
interface gray2bin_arbiter_if
   import g2b_pkg::*;
   #(
      parameter int W = G2B_W,
      parameter int N = G2B_N
   );

   localparam int IDW = calc_idw(N);

   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_gray;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic [W-1:0]   out_gray;
   logic [W-1:0]   out_bin;
   logic [IDW-1:0] out_id;
   logic           out_ready;

   modport slave (
      input  req_valid, req_gray, out_ready,
      output req_ready, out_valid, out_gray, out_bin, out_id
   );

   modport master (
      output req_valid, req_gray, out_ready,
      input  req_ready, out_valid, out_gray, out_bin, out_id
   );

endinterface

// File: rtl/gray2bin_comb.sv
// Purely combinational W-bit Gray-to-binary converter.
//   gray[W]  Gray code in
//   bin[W]   binary value out
module gray2bin_comb #(
   parameter int W = 4
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   // Binary bit i is the XOR of all Gray bits from i up to the MSB; written
   // as a reduction of the shifted code so no bit depends on another output bit.
   always_comb begin
      bin = '0;
      for (int i = 0; i < W; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/gray2bin_arbiter.sv
// Shares one Gray-to-binary converter between N requesters. A round-robin
// arbiter picks one presented code per cycle, the winner is converted and
// held in a one-entry output slot, drained through out_valid/out_ready.
//   clk  single clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  gray2bin_arbiter_if.slave (requests in, grants and result out)
module gray2bin_arbiter
   import g2b_pkg::*;
   #(
      parameter int W = G2B_W,
      parameter int N = G2B_N
   ) (
      input logic             clk,
      input logic             rst,
      gray2bin_arbiter_if.slave bus
   );

   localparam int IDW = calc_idw(N);

   slot_state_e    state_r;
   slot_state_e    state_next_s;
   logic [IDW-1:0] ptr_r;
   logic [IDW-1:0] ptr_next_s;
   logic [IDW-1:0] winner_s;
   logic           found_s;
   logic           can_accept_s;
   logic           accept_s;
   logic [N-1:0]   req_ready_s;
   logic [W-1:0]   win_gray_s;
   logic [W-1:0]   win_bin_s;
   logic [W-1:0]   out_gray_r;
   logic [W-1:0]   out_bin_r;
   logic [IDW-1:0] out_id_r;

   // Round-robin scan: first valid requester starting at ptr, wrapping at N.
   always_comb begin
      int idx;
      idx      = 0;
      found_s  = 1'b0;
      winner_s = ptr_r;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_r) + k;
         if (idx >= N) begin
            idx = idx - N;
         end else begin
            idx = idx;
         end
         if (!found_s && bus.req_valid[idx]) begin
            found_s  = 1'b1;
            winner_s = IDW'(idx);
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Grant generation; rst gates it so no grant is seen while in reset.
   always_comb begin
      can_accept_s = (state_r == SLOT_EMPTY) || bus.out_ready;
      accept_s     = !rst && can_accept_s && found_s;
      req_ready_s  = '0;
      if (accept_s) begin
         req_ready_s[winner_s] = 1'b1;
      end else begin
         req_ready_s = '0;
      end
   end

   // Accept mux and pointer advance past the winner.
   always_comb begin
      win_gray_s = bus.req_gray[int'(winner_s)*W +: W];
      if (winner_s == IDW'(N - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = winner_s + IDW'(1);
      end
   end

   gray2bin_comb #(.W(W)) u_conv (
      .gray (win_gray_s),
      .bin  (win_bin_s)
   );

   // Slot next state: refill wins over drain when both happen on one edge.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         SLOT_EMPTY: begin
            if (accept_s) begin
               state_next_s = SLOT_FULL;
            end else begin
               state_next_s = SLOT_EMPTY;
            end
         end
         SLOT_FULL: begin
            if (accept_s) begin
               state_next_s = SLOT_FULL;
            end else if (bus.out_ready) begin
               state_next_s = SLOT_EMPTY;
            end else begin
               state_next_s = SLOT_FULL;
            end
         end
         default: state_next_s = SLOT_EMPTY;
      endcase
   end

   // Slot state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= SLOT_EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Pointer and data registers; data holds its last value after a drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r      <= '0;
         out_gray_r <= '0;
         out_bin_r  <= '0;
         out_id_r   <= '0;
      end else if (accept_s) begin
         ptr_r      <= ptr_next_s;
         out_gray_r <= win_gray_s;
         out_bin_r  <= win_bin_s;
         out_id_r   <= winner_s;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.out_valid = (state_r == SLOT_FULL);
   assign bus.out_gray  = out_gray_r;
   assign bus.out_bin   = out_bin_r;
   assign bus.out_id    = out_id_r;

endmodule

// File: tb/tb_gray2bin_arbiter.sv
module tb_gray2bin_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] rv [2];
   logic [3:0] rg [2][3];
   logic       ordy [2];

   int n_tests = 0;
   int n_fail  = 0;

   // reference slot per instance: 0 = N=2 DUT, 1 = N=3 DUT
   int m_valid [2];
   int m_gray  [2];
   int m_bin   [2];
   int m_id    [2];
   int m_ptr   [2];
   int nreq    [2] = '{2, 3};

   always #5 clk = ~clk;

   gray2bin_arbiter_if #(.W(4), .N(2)) bus_a ();
   gray2bin_arbiter_if #(.W(4), .N(3)) bus_b ();

   assign bus_a.req_valid = rv[0][1:0];
   assign bus_a.req_gray  = {rg[0][1], rg[0][0]};
   assign bus_a.out_ready = ordy[0];
   assign bus_b.req_valid = rv[1];
   assign bus_b.req_gray  = {rg[1][2], rg[1][1], rg[1][0]};
   assign bus_b.out_ready = ordy[1];

   gray2bin_arbiter #(.W(4), .N(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   gray2bin_arbiter #(.W(4), .N(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   function automatic logic [31:0] obs_ready(int d);
      return (d == 0) ? {30'd0, bus_a.req_ready} : {29'd0, bus_b.req_ready};
   endfunction
   function automatic logic [31:0] obs_valid(int d);
      return (d == 0) ? {31'd0, bus_a.out_valid} : {31'd0, bus_b.out_valid};
   endfunction
   function automatic logic [31:0] obs_gray(int d);
      return (d == 0) ? {28'd0, bus_a.out_gray} : {28'd0, bus_b.out_gray};
   endfunction
   function automatic logic [31:0] obs_bin(int d);
      return (d == 0) ? {28'd0, bus_a.out_bin} : {28'd0, bus_b.out_bin};
   endfunction
   function automatic logic [31:0] obs_id(int d);
      return (d == 0) ? {31'd0, bus_a.out_id} : {30'd0, bus_b.out_id};
   endfunction

   // binary value whose Gray encoding equals g (search, not a bit formula)
   function automatic int ref_bin(int g);
      for (int b = 0; b < 16; b++) begin
         if ((b ^ (b >> 1)) == g) return b;
      end
      return -1;
   endfunction

   // requester granted this cycle by the rules, or -1 for no grant
   function automatic int model_win(int d);
      if (rst) return -1;
      if (m_valid[d] != 0 && !ordy[d]) return -1;
      for (int k = 0; k < nreq[d]; k++) begin
         int i;
         i = (m_ptr[d] + k) % nreq[d];
         if (rv[d][i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 0; m_gray[d] = 0; m_bin[d] = 0; m_id[d] = 0; m_ptr[d] = 0;
      end
   endtask

   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         int w;
         w = model_win(d);
         if (rst) begin
            m_valid[d] = 0; m_gray[d] = 0; m_bin[d] = 0; m_id[d] = 0; m_ptr[d] = 0;
         end else if (w >= 0) begin
            m_valid[d] = 1;
            m_gray[d]  = int'(rg[d][w]);
            m_bin[d]   = ref_bin(int'(rg[d][w]));
            m_id[d]    = w;
            m_ptr[d]   = (w + 1) % nreq[d];
         end else if (m_valid[d] != 0 && ordy[d]) begin
            m_valid[d] = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // compare both DUTs against the model mid-cycle, then take one edge
   task automatic cycle();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         int w;
         w = model_win(d);
         check($sformatf("ready%0d", d), obs_ready(d), (w < 0) ? 0 : (1 << w));
         check($sformatf("valid%0d", d), obs_valid(d), m_valid[d]);
         check($sformatf("gray%0d", d),  obs_gray(d),  m_gray[d]);
         check($sformatf("bin%0d", d),   obs_bin(d),   m_bin[d]);
         check($sformatf("id%0d", d),    obs_id(d),    m_id[d]);
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      int exp_id;
      for (int d = 0; d < 2; d++) begin
         rv[d] = 3'b000; ordy[d] = 1'b1;
         for (int i = 0; i < 3; i++) rg[d][i] = 4'b0000;
      end
      model_reset();
      repeat (2) cycle();
      rst = 1'b0;

      // full sweep, requester 0 alone
      for (int i = 0; i < 16; i++) begin
         rg[0][0] = 4'(i ^ (i >> 1));
         rv[0]    = 3'b001;
         cycle();
         check("sweep_bin", {28'd0, bus_a.out_bin}, i);
         check("sweep_id", {31'd0, bus_a.out_id}, 0);
      end
      check("tbl_1000", {28'd0, bus_a.out_bin}, 32'b1111);

      // round-robin; last grant was 0 so requester 1 goes first
      rg[0][0] = 4'b0011; rg[0][1] = 4'b1111; rv[0] = 3'b011;
      exp_id = 1;
      for (int j = 0; j < 4; j++) begin
         cycle();
         check("rr_id", {31'd0, bus_a.out_id}, exp_id);
         check("rr_bin", {28'd0, bus_a.out_bin}, (exp_id == 1) ? 32'b1010 : 32'b0010);
         exp_id = exp_id ^ 1;
      end

      // backpressure: slot holds 0010 from requester 0
      ordy[0] = 1'b0;
      repeat (3) begin
         cycle();
         check("bp_bin", {28'd0, bus_a.out_bin}, 32'b0010);
         check("bp_ready", {30'd0, bus_a.req_ready}, 0);
      end
      ordy[0] = 1'b1;
      #1;
      check("bp_regrant", {30'd0, bus_a.req_ready}, 32'b10);
      cycle();
      check("bp_id", {31'd0, bus_a.out_id}, 1);
      check("bp_valid", {31'd0, bus_a.out_valid}, 1);

      // idle drain
      rv[0] = 3'b000;
      cycle();
      rg[0][0] = 4'b0101; rv[0] = 3'b001; ordy[0] = 1'b0;
      cycle();
      rv[0] = 3'b000;
      repeat (2) begin
         cycle();
         check("idle_bin", {28'd0, bus_a.out_bin}, 32'b0110);
      end
      ordy[0] = 1'b1;
      cycle();
      check("idle_drop", {31'd0, bus_a.out_valid}, 0);
      ordy[0] = 1'b0;
      cycle();
      check("idle_hold", {28'd0, bus_a.out_bin}, 32'b0110);
      rv[0] = 3'b011;
      #1;
      check("idle_ptr", {30'd0, bus_a.req_ready}, 32'b10);
      ordy[0] = 1'b1;
      cycle();

      // asynchronous reset while full with 1101
      rg[0][0] = 4'b1101; rv[0] = 3'b001;
      cycle();
      ordy[0] = 1'b0;
      check("pre_rst_gray", {28'd0, bus_a.out_gray}, 32'b1101);
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_valid", {31'd0, bus_a.out_valid}, 0);
      check("rst_gray", {28'd0, bus_a.out_gray}, 0);
      check("rst_bin", {28'd0, bus_a.out_bin}, 0);
      check("rst_ready", {30'd0, bus_a.req_ready}, 0);
      cycle();
      rst = 1'b0;
      rv[0] = 3'b011; ordy[0] = 1'b1;
      #1;
      check("rst_first_grant", {30'd0, bus_a.req_ready}, 32'b01);
      cycle();
      rv[0] = 3'b000;

      // N = 3 wrap: bring ptr to 2, then requesters 2 and 0 only
      rv[1] = 3'b010; rg[1][1] = 4'b0001;
      cycle();
      rg[1][0] = 4'b1000; rg[1][2] = 4'b0110; rv[1] = 3'b101;
      exp_id = 2;
      for (int j = 0; j < 3; j++) begin
         cycle();
         check("n3_id", {30'd0, bus_b.out_id}, exp_id);
         check("n3_valid", {31'd0, bus_b.out_valid}, 1);
         exp_id = (exp_id == 2) ? 0 : 2;
      end

      // randomized traffic on both instances
      for (int j = 0; j < 300; j++) begin
         for (int d = 0; d < 2; d++) begin
            rv[d]   = 3'($urandom);
            ordy[d] = 1'($urandom_range(0, 1));
            for (int i = 0; i < 3; i++) rg[d][i] = 4'($urandom);
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
